// File: rtl/gb_lcd_pkg.sv
// Shared LCD definitions: STAT mode encodings and default dot-timing parameters.
// Used by the pixel transmitter, the LCD block and the STAT logic.
package gb_lcd_pkg;

    localparam int unsigned DEF_LINE_DOTS = 456;
    localparam int unsigned DEF_LINES     = 154;
    localparam int unsigned DEF_VIS_LINES = 144;
    localparam int unsigned DEF_VIS_W     = 160;
    localparam int unsigned DEF_OAM_DOTS  = 80;
    localparam int unsigned DEF_M3_DELAY  = 12;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } lcd_mode_e;

endpackage

// File: rtl/gb_lcd_dot_timing.sv
// Dot/line counters for the LCD: hcnt and ly with wrap, first-line tracking,
// lcd_on clear, and the frame-end (lcd_vs) and vblank_start markers.
module gb_lcd_dot_timing
    import gb_lcd_pkg::*;
#(
    parameter int unsigned LINE_DOTS = DEF_LINE_DOTS,
    parameter int unsigned LINES     = DEF_LINES,
    parameter int unsigned VIS_LINES = DEF_VIS_LINES
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic       lcd_on,
    output logic [8:0] hcnt,
    output logic [7:0] ly,
    output logic [8:0] hcnt_next,
    output logic [7:0] ly_next,
    output logic       first_line_next,
    output logic       line_end,
    output logic       lcd_vs,
    output logic       vblank_start
);

    localparam logic [8:0] HCNT_LAST = 9'(LINE_DOTS - 1);
    localparam logic [7:0] LY_LAST   = 8'(LINES - 1);
    localparam logic [7:0] LY_VBL    = 8'(VIS_LINES);

    logic [8:0] hcnt_q, hcnt_d;
    logic [7:0] ly_q, ly_d;
    logic       first_line_q, first_line_d;
    logic       lcd_vs_q, lcd_vs_d;
    logic       vblank_start_q, vblank_start_d;

    assign line_end = (hcnt_q == HCNT_LAST);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        hcnt_d         = hcnt_q;
        ly_d           = ly_q;
        first_line_d   = first_line_q;
        lcd_vs_d       = lcd_vs_q;
        vblank_start_d = vblank_start_q;
        if (!lcd_on) begin
            hcnt_d         = '0;
            ly_d           = '0;
            first_line_d   = 1'b1;
            lcd_vs_d       = 1'b0;
            vblank_start_d = 1'b0;
        end else if (ce) begin
            if (line_end) begin
                hcnt_d       = '0;
                ly_d         = (ly_q == LY_LAST) ? '0 : ly_q + 8'd1;
                first_line_d = 1'b0;
            end else begin
                hcnt_d = hcnt_q + 9'd1;
            end
            lcd_vs_d       = (ly_d == LY_VBL);
            vblank_start_d = (ly_d == LY_VBL) && (hcnt_d == '0);
        end
    end

    always_ff @(posedge clk_sys) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            hcnt_q         <= '0;
            ly_q           <= '0;
            first_line_q   <= 1'b1;
            lcd_vs_q       <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hcnt_q         <= hcnt_d;
            ly_q           <= ly_d;
            first_line_q   <= first_line_d;
            lcd_vs_q       <= lcd_vs_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign hcnt            = hcnt_q;
    assign ly              = ly_q;
    assign hcnt_next       = hcnt_d;
    assign ly_next         = ly_d;
    assign first_line_next = first_line_d;
    assign lcd_vs          = lcd_vs_q;
    assign vblank_start    = vblank_start_q;

endmodule

// File: rtl/gb_lcd_tx.sv
// Pixel transmitter: drains the PPU pixel FIFO during mode 3 and drives the
// LCD writer strobe/data, STAT mode, hblank pulse and sticky underrun flag.
module gb_lcd_tx
    import gb_lcd_pkg::*;
#(
    parameter int unsigned LINE_DOTS = DEF_LINE_DOTS,
    parameter int unsigned LINES     = DEF_LINES,
    parameter int unsigned VIS_LINES = DEF_VIS_LINES,
    parameter int unsigned VIS_W     = DEF_VIS_W,
    parameter int unsigned OAM_DOTS  = DEF_OAM_DOTS,
    parameter int unsigned M3_DELAY  = DEF_M3_DELAY
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        lcd_on,
    input  logic        pix_valid,
    input  logic [14:0] pix_data,
    output logic        pix_ready,
    output logic        lcd_clkena,
    output logic [14:0] data,
    output logic [1:0]  mode,
    output logic        lcd_vs,
    output logic [7:0]  ly,
    output logic        hblank_start,
    output logic        vblank_start,
    output logic        underrun
);

    localparam logic [8:0] HCNT_XFER  = 9'(OAM_DOTS);
    localparam logic [8:0] PUSH_START = 9'(OAM_DOTS + M3_DELAY);
    localparam logic [7:0] LY_VIS     = 8'(VIS_LINES);
    localparam logic [7:0] X_END      = 8'(VIS_W);

    logic [8:0]  hcnt, hcnt_next;
    logic [7:0]  ly_next;
    logic        first_line_next, line_end;
    logic        accept;

    lcd_mode_e   mode_q, mode_d;
    logic [7:0]  x_q, x_d;
    logic        lcd_clkena_q, lcd_clkena_d;
    logic [14:0] data_q, data_d;
    logic        hblank_start_q, hblank_start_d;
    logic        underrun_q, underrun_d;

    gb_lcd_dot_timing #(
        .LINE_DOTS (LINE_DOTS),
        .LINES     (LINES),
        .VIS_LINES (VIS_LINES)
    ) u_timing (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .ce              (ce),
        .lcd_on          (lcd_on),
        .hcnt            (hcnt),
        .ly              (ly),
        .hcnt_next       (hcnt_next),
        .ly_next         (ly_next),
        .first_line_next (first_line_next),
        .line_end        (line_end),
        .lcd_vs          (lcd_vs),
        .vblank_start    (vblank_start)
    );

    // x reaching VIS_W closes the window for the rest of the line; after an
    // underrun the next line's hcnt is below PUSH_START, which keeps it closed.
    assign pix_ready = ce & lcd_on & (ly < LY_VIS) & (hcnt >= PUSH_START) & (x_q < X_END);
    assign accept    = pix_valid & pix_ready;

    always_comb begin
        x_d          = x_q;
        lcd_clkena_d = lcd_clkena_q;
        data_d       = data_q;
        underrun_d   = underrun_q;
        if (!lcd_on) begin
            x_d          = '0;
            lcd_clkena_d = 1'b0;
            underrun_d   = 1'b0;
        end else if (ce) begin
            lcd_clkena_d = accept;
            if (accept) data_d = pix_data;
            if (hcnt_next == HCNT_XFER) x_d = '0;
            else if (accept)            x_d = x_q + 8'd1;
            if (line_end && (mode_q == MODE_XFER) && (x_d < X_END)) underrun_d = 1'b1;
        end
    end

    // Mode is computed from the post-edge counters so it stays aligned with hcnt/ly.
    always_comb begin
        mode_d = mode_q;
        if (!lcd_on) begin
            mode_d = MODE_HBLANK;
        end else if (ce) begin
            if (ly_next >= LY_VIS)           mode_d = MODE_VBLANK;
            else if (hcnt_next < HCNT_XFER)  mode_d = first_line_next ? MODE_HBLANK : MODE_OAM;
            else if (x_d < X_END)            mode_d = MODE_XFER;
            else                             mode_d = MODE_HBLANK;
        end
    end

    always_comb begin
        hblank_start_d = hblank_start_q;
        if (!lcd_on)  hblank_start_d = 1'b0;
        else if (ce)  hblank_start_d = (mode_q == MODE_XFER) && (mode_d == MODE_HBLANK);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) mode_q <= MODE_HBLANK;
        else       mode_q <= mode_d;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            x_q            <= '0;
            lcd_clkena_q   <= 1'b0;
            data_q         <= '0;
            hblank_start_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            x_q            <= x_d;
            lcd_clkena_q   <= lcd_clkena_d;
            data_q         <= data_d;
            hblank_start_q <= hblank_start_d;
            underrun_q     <= underrun_d;
        end
    end

    assign mode         = mode_q;
    assign lcd_clkena   = lcd_clkena_q;
    assign data         = data_q;
    assign hblank_start = hblank_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_gb_lcd_tx.sv
// Directed bench for gb_lcd_tx: own dot/line model, per-line statistics and a
// pixel scoreboard filled on accept and drained on each lcd_clkena strobe.
module tb_gb_lcd_tx;

    localparam int LINE_DOTS = 456;

    typedef struct {
        int m0, m1, m2, m3;
        int pix, hb, vs, vb;
        int first_acc, first_mode;
    } line_stat_t;

    logic        clk_sys = 1'b0;
    logic        reset, ce, lcd_on, pix_valid;
    logic [14:0] pix_data;
    logic        pix_ready, lcd_clkena, lcd_vs, hblank_start, vblank_start, underrun;
    logic [14:0] data;
    logic [1:0]  mode;
    logic [7:0]  ly;

    int          checks = 0;
    int          failures = 0;
    logic [14:0] exp_q[$];
    int          pix_seq = 0;
    int          hcnt_m = 0;
    int          ly_m = 0;
    logic        hold_en = 1'b0;
    logic [29:0] prev_out = '0;
    line_stat_t  cur;
    line_stat_t  ls[154];

    gb_lcd_tx dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ce           (ce),
        .lcd_on       (lcd_on),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .lcd_clkena   (lcd_clkena),
        .data         (data),
        .mode         (mode),
        .lcd_vs       (lcd_vs),
        .ly           (ly),
        .hblank_start (hblank_start),
        .vblank_start (vblank_start),
        .underrun     (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void clr_cur();
        cur.m0 = 0; cur.m1 = 0; cur.m2 = 0; cur.m3 = 0;
        cur.pix = 0; cur.hb = 0; cur.vs = 0; cur.vb = 0;
        cur.first_acc = -1; cur.first_mode = -1;
    endfunction

    function automatic logic [29:0] out_vec();
        return {mode, ly, lcd_clkena, data, lcd_vs, hblank_start, vblank_start, underrun};
    endfunction

    // One clock: drive inputs, observe the state in force for this dot, then
    // step the model and check the strobe/pixel that the edge produced.
    task automatic cycle(input logic ce_v, input logic valid_v);
        logic        acc;
        logic [14:0] got;
        ce        = ce_v;
        pix_valid = valid_v;
        pix_data  = 15'(pix_seq);
        #1;
        acc = ce_v & valid_v & (pix_ready === 1'b1);
        if (acc) begin
            exp_q.push_back(pix_data);
            pix_seq++;
            cur.pix++;
            if (cur.first_acc < 0) cur.first_acc = hcnt_m;
        end
        if (ce_v && lcd_on) begin
            if (hcnt_m == 0) begin
                cur.first_mode = int'(mode);
                check("ly_at_line_start", 32'(ly), 32'(ly_m));
            end
            case (mode)
                2'd0: cur.m0++;
                2'd1: cur.m1++;
                2'd2: cur.m2++;
                2'd3: cur.m3++;
                default: ;
            endcase
            if (hblank_start === 1'b1) cur.hb++;
            if (lcd_vs === 1'b1)       cur.vs++;
            if (vblank_start === 1'b1) cur.vb++;
            if (hcnt_m == LINE_DOTS - 1) begin
                ls[ly_m] = cur;
                clr_cur();
            end
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
        if (ce_v && lcd_on) begin
            if (hcnt_m == LINE_DOTS - 1) begin
                hcnt_m = 0;
                ly_m   = (ly_m == 153) ? 0 : ly_m + 1;
            end else begin
                hcnt_m++;
            end
        end
        if (ce_v) begin
            if (acc || lcd_clkena !== 1'b0) begin
                check("lcd_clkena_vs_accept", 32'(lcd_clkena), 32'(acc));
                if (acc && exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    check("pixel_data", 32'(data), 32'(got));
                end
            end
        end else if (hold_en) begin
            check("hold_without_ce", 32'(out_vec()), 32'(prev_out));
        end
        prev_out = out_vec();
    endtask

    task automatic run_to(input int ly_t, input int h_t, input logic valid_v);
        int n;
        n = 0;
        while (!(ly_m == ly_t && hcnt_m == h_t) && n < 80000) begin
            cycle(1'b1, valid_v);
            n++;
        end
        check("run_to_reached", 32'(n < 80000), 32'd1);
    endtask

    task automatic chk_line(input string tag, input int idx, input int m0, input int m1,
                            input int m2, input int m3, input int pix, input int hb);
        check({tag, "_mode0_dots"}, ls[idx].m0, m0);
        check({tag, "_mode1_dots"}, ls[idx].m1, m1);
        check({tag, "_mode2_dots"}, ls[idx].m2, m2);
        check({tag, "_mode3_dots"}, ls[idx].m3, m3);
        check({tag, "_pixels"},     ls[idx].pix, pix);
        check({tag, "_hblank_pulses"}, ls[idx].hb, hb);
    endtask

    initial begin
        int k;
        reset = 1'b1; ce = 1'b0; lcd_on = 1'b0; pix_valid = 1'b0; pix_data = '0;
        clr_cur();
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        #1;
        check("reset_mode", 32'(mode), 0);
        check("reset_ly", 32'(ly), 0);
        check("reset_lcd_clkena", 32'(lcd_clkena), 0);
        check("reset_data", 32'(data), 0);
        check("reset_lcd_vs", 32'(lcd_vs), 0);
        check("reset_underrun", 32'(underrun), 0);
        check("reset_pulses", 32'({hblank_start, vblank_start}), 0);
        ce = 1'b1;
        #1;
        check("pix_ready_lcd_off", 32'(pix_ready), 0);
        ce = 1'b0;
        prev_out = out_vec();

        // Nominal lines: first line reports mode 0 in place of mode 2.
        lcd_on = 1'b1;
        run_to(1, 0, 1'b1);
        chk_line("ly0_first", 0, 284, 0, 0, 172, 160, 1);
        check("ly0_first_mode", ls[0].first_mode, 0);
        check("ly0_first_accept_dot", ls[0].first_acc, 92);
        run_to(2, 0, 1'b1);
        chk_line("ly1", 1, 204, 0, 80, 172, 160, 1);
        check("ly1_first_mode", ls[1].first_mode, 2);
        check("ly1_first_accept_dot", ls[1].first_acc, 92);

        // FIFO empty for 20 dots mid-transfer.
        run_to(2, 150, 1'b1);
        repeat (20) cycle(1'b1, 1'b0);
        run_to(3, 0, 1'b1);
        chk_line("ly2_stall", 2, 184, 0, 80, 192, 160, 1);

        // ce every 4th clock with random pix_valid; outputs must hold between ce.
        hold_en = 1'b1;
        k = 0;
        while (!(ly_m == 4 && hcnt_m == 0) && k < 20000) begin
            k++;
            cycle(k % 4 == 0, $urandom_range(0, 3) != 0);
        end
        hold_en = 1'b0;
        check("slow_ce_reached_ly4", 32'(k < 20000), 32'd1);
        check("ly3_slow_pixels", ls[3].pix, 160);
        check("ly3_slow_mode2_dots", ls[3].m2, 80);
        check("ly3_slow_mode3_plus_0", ls[3].m3 + ls[3].m0, 376);
        check("ly3_slow_hblank_pulses", ls[3].hb, 1);

        // Starved line: underrun at line end, next line starts in mode 2.
        run_to(5, 0, 1'b1);
        check("underrun_before_starve", 32'(underrun), 0);
        run_to(6, 0, 1'b0);
        chk_line("ly5_starved", 5, 0, 0, 80, 376, 0, 0);
        check("underrun_after_starve", 32'(underrun), 1);
        check("ly6_start_mode", 32'(mode), 2);
        run_to(7, 200, 1'b1);
        check("underrun_sticky", 32'(underrun), 1);

        // lcd_on falls on a non-ce cycle mid-line.
        lcd_on = 1'b0;
        cycle(1'b0, 1'b1);
        hcnt_m = 0; ly_m = 0;
        clr_cur();
        check("lcd_off_ly", 32'(ly), 0);
        check("lcd_off_mode", 32'(mode), 0);
        check("lcd_off_lcd_clkena", 32'(lcd_clkena), 0);
        check("lcd_off_underrun", 32'(underrun), 0);
        check("lcd_off_lcd_vs", 32'(lcd_vs), 0);
        repeat (3) cycle(1'b1, 1'b1);
        check("lcd_off_hold_ly", 32'(ly), 0);
        check("lcd_off_no_pending_pixels", exp_q.size(), 0);
        lcd_on = 1'b1;
        run_to(2, 0, 1'b1);
        chk_line("reon_ly0", 0, 284, 0, 0, 172, 160, 1);
        check("reon_ly0_first_mode", ls[0].first_mode, 0);
        chk_line("reon_ly1", 1, 204, 0, 80, 172, 160, 1);

        // Vertical blank and frame wrap.
        run_to(144, 0, 1'b1);
        check("vbl_entry_vblank_start", 32'(vblank_start), 1);
        check("vbl_entry_lcd_vs", 32'(lcd_vs), 1);
        check("vbl_entry_mode", 32'(mode), 1);
        run_to(146, 0, 1'b1);
        chk_line("ly143", 143, 204, 0, 80, 172, 160, 1);
        check("ly143_lcd_vs_dots", ls[143].vs, 0);
        chk_line("ly144", 144, 0, 456, 0, 0, 0, 0);
        check("ly144_lcd_vs_dots", ls[144].vs, 456);
        check("ly144_vblank_pulses", ls[144].vb, 1);
        check("ly145_lcd_vs_dots", ls[145].vs, 0);
        check("ly145_vblank_pulses", ls[145].vb, 0);
        check("ly145_mode1_dots", ls[145].m1, 456);
        run_to(0, 0, 1'b1);
        check("ly153_mode1_dots", ls[153].m1, 456);
        check("wrap_ly", 32'(ly), 0);
        check("wrap_mode", 32'(mode), 2);
        check("wrap_lcd_vs", 32'(lcd_vs), 0);
        check("frame_end_no_pending_pixels", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
